// File: rtl/cmul_stream_if.sv
// Valid/ready stream bundle for cmul_stream: constant, operand and tag in; redundant product out.
interface cmul_stream_if #(
    parameter int unsigned LIMBS     = 8,
    parameter int unsigned LIMB_W    = 48,
    parameter int unsigned MAX_SHIFT = 3,
    parameter int unsigned TAG_W     = 4
);
    localparam int unsigned DIN_W  = LIMBS * LIMB_W - MAX_SHIFT;
    localparam int unsigned DOUT_W = LIMBS * (LIMB_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_k;
    logic [DIN_W-1:0]  in_din;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] out_dout;
    logic              out_err;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_k, in_din, in_tag, out_ready,
        input  in_ready, out_valid, out_dout, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_k, in_din, in_tag, out_ready,
        output in_ready, out_valid, out_dout, out_err, out_tag
    );
endinterface

// File: rtl/cmul_stream.sv
// Elastic small-constant multiplier: k*din as two shifted copies of din summed limb-wise,
// leaving the result in redundant (carry-free between limbs) form.
module cmul_stream #(
    parameter int unsigned LIMBS     = 8,
    parameter int unsigned LIMB_W    = 48,
    parameter int unsigned MAX_SHIFT = 3,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned TAG_W     = 4
) (
    input logic          clk,
    input logic          rstn,
    cmul_stream_if.slave bus
);
    localparam int unsigned TERM_W = LIMBS * LIMB_W;
    localparam int unsigned SUM_W  = LIMB_W + 1;
    localparam int unsigned DOUT_W = LIMBS * SUM_W;

    function automatic logic [DOUT_W-1:0] limb_sum(input logic [TERM_W-1:0] a,
                                                   input logic [TERM_W-1:0] b);
        logic [DOUT_W-1:0] s;
        s = '0;
        for (int unsigned l = 0; l < LIMBS; l++) begin
            s[l*SUM_W +: SUM_W] = SUM_W'(a[l*LIMB_W +: LIMB_W]) + SUM_W'(b[l*LIMB_W +: LIMB_W]);
        end
        return s;
    endfunction

    logic [TERM_W-1:0] din_ext;
    logic [TERM_W-1:0] a_c;
    logic [TERM_W-1:0] b_c;
    logic              err_c;
    logic [2:0]        pop_c;

    assign din_ext = TERM_W'(bus.in_din);

    // Scanning upward, each set bit pushes the previous term into B, so A ends on the msb.
    always_comb begin
        a_c   = '0;
        b_c   = '0;
        err_c = 1'b0;
        pop_c = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.in_k[i[1:0]]) begin
                pop_c = pop_c + 3'd1;
                b_c   = a_c;
                a_c   = din_ext << i;
                if (i > MAX_SHIFT) err_c = 1'b1;
            end
        end
        if (pop_c > 3'd2) err_c = 1'b1;
        if (err_c) begin
            a_c = '0;
            b_c = '0;
        end
    end

    logic [TERM_W-1:0] fin_a;
    logic [TERM_W-1:0] fin_b;
    logic              fin_err;
    logic [TAG_W-1:0]  fin_tag;
    logic              fin_avail;
    logic              in_ready_c;

    logic              out_valid_q;
    logic              out_valid_d;
    logic              out_load;
    logic              out_leave;
    logic [DOUT_W-1:0] out_dout_q;
    logic              out_err_q;
    logic [TAG_W-1:0]  out_tag_q;

    assign out_leave   = out_valid_q && bus.out_ready;
    assign out_load    = fin_avail && (!out_valid_q || out_leave);
    assign out_valid_d = out_load || (out_valid_q && !out_leave);

    generate
        if (STAGES == 2) begin : g_two
            logic              s1_valid_q;
            logic              s1_valid_d;
            logic              s1_load;
            logic              s1_leave;
            logic [TERM_W-1:0] s1_a_q;
            logic [TERM_W-1:0] s1_b_q;
            logic              s1_err_q;
            logic [TAG_W-1:0]  s1_tag_q;

            assign s1_leave   = out_load;
            assign in_ready_c = rstn && (!s1_valid_q || s1_leave);
            assign s1_load    = bus.in_valid && in_ready_c;
            assign s1_valid_d = s1_load || (s1_valid_q && !s1_leave);

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s1_valid_q <= 1'b0;
                    s1_a_q     <= '0;
                    s1_b_q     <= '0;
                    s1_err_q   <= 1'b0;
                    s1_tag_q   <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    if (s1_load) begin
                        s1_a_q   <= a_c;
                        s1_b_q   <= b_c;
                        s1_err_q <= err_c;
                        s1_tag_q <= bus.in_tag;
                    end
                end
            end

            assign fin_avail = s1_valid_q;
            assign fin_a     = s1_a_q;
            assign fin_b     = s1_b_q;
            assign fin_err   = s1_err_q;
            assign fin_tag   = s1_tag_q;
        end else if (STAGES == 1) begin : g_one
            assign in_ready_c = rstn && (!out_valid_q || out_leave);
            assign fin_avail  = bus.in_valid && in_ready_c;
            assign fin_a      = a_c;
            assign fin_b      = b_c;
            assign fin_err    = err_c;
            assign fin_tag    = bus.in_tag;
        end else begin : g_bad_stages
            $error("cmul_stream: STAGES must be 1 or 2");
        end
    endgenerate

    // Output stage; payload registers only move on a load so held results stay put.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_dout_q  <= '0;
            out_err_q   <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (out_load) begin
                out_dout_q <= limb_sum(fin_a, fin_b);
                out_err_q  <= fin_err;
                out_tag_q  <= fin_tag;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_dout  = out_dout_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_cmul_stream.sv
// Scoreboard bench for cmul_stream on a 4x16-bit limb configuration with two stages.
module tb_cmul_stream;
    localparam int unsigned LIMBS     = 4;
    localparam int unsigned LIMB_W    = 16;
    localparam int unsigned MAX_SHIFT = 3;
    localparam int unsigned STAGES    = 2;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned DIN_W     = LIMBS * LIMB_W - MAX_SHIFT;
    localparam int unsigned TERM_W    = LIMBS * LIMB_W;
    localparam int unsigned SUM_W     = LIMB_W + 1;
    localparam int unsigned DOUT_W    = LIMBS * SUM_W;

    typedef struct {
        logic [DOUT_W-1:0] dout;
        logic              err;
        logic [TAG_W-1:0]  tag;
        logic [79:0]       prod;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [79:0] mon_acc;

    cmul_stream_if #(.LIMBS(LIMBS), .LIMB_W(LIMB_W), .MAX_SHIFT(MAX_SHIFT), .TAG_W(TAG_W)) bus ();

    cmul_stream #(.LIMBS(LIMBS), .LIMB_W(LIMB_W), .MAX_SHIFT(MAX_SHIFT), .STAGES(STAGES),
                  .TAG_W(TAG_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // Reference: per-limb sum of each shifted copy of din, built bit by bit from k.
    function automatic void model(input logic [3:0] k, input logic [DIN_W-1:0] din,
                                  output logic [DOUT_W-1:0] dout, output logic err);
        int kv, pc;
        logic [TERM_W-1:0] t;
        logic [SUM_W-1:0] limb;
        kv = int'(k);
        pc = 0;
        dout = '0;
        err = 1'b0;
        for (int i = 0; i < 4; i++) if (((kv >> i) & 1) == 1) pc++;
        if (pc > 2) begin
            err = 1'b1;
            return;
        end
        for (int l = 0; l < int'(LIMBS); l++) begin
            limb = '0;
            for (int i = 0; i < 4; i++) begin
                if (((kv >> i) & 1) == 1) begin
                    t = TERM_W'(din) << i;
                    limb = limb + SUM_W'(t[l*LIMB_W +: LIMB_W]);
                end
            end
            dout[l*SUM_W +: SUM_W] = limb;
        end
    endfunction

    function automatic logic [DIN_W-1:0] rand_din();
        return DIN_W'({$urandom(), $urandom()});
    endfunction

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            n_out++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: dout=%h tag=%0h, required no output", bus.out_dout, bus.out_tag);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_dout !== mon_e.dout || bus.out_err !== mon_e.err || bus.out_tag !== mon_e.tag) begin
                    n_err++;
                    $display("FAIL scoreboard: dout=%h err=%0b tag=%0h, required dout=%h err=%0b tag=%0h",
                             bus.out_dout, bus.out_err, bus.out_tag, mon_e.dout, mon_e.err, mon_e.tag);
                end
                if (!mon_e.err) begin
                    mon_acc = '0;
                    for (int l = 0; l < int'(LIMBS); l++)
                        mon_acc = mon_acc + (80'(bus.out_dout[l*SUM_W +: SUM_W]) << (l*LIMB_W));
                    n_cmp++;
                    if (mon_acc !== mon_e.prod) begin
                        n_err++;
                        $display("FAIL k_times_din: value=%h, required %h", mon_acc, mon_e.prod);
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] k, input logic [DIN_W-1:0] din,
                        input logic [TAG_W-1:0] tag, output int acc_cyc);
        exp_t e;
        bit done;
        done = 1'b0;
        model(k, din, e.dout, e.err);
        e.tag  = tag;
        e.prod = 80'(k) * 80'(din);
        bus.in_valid = 1'b1;
        bus.in_k     = k;
        bus.in_din   = din;
        bus.in_tag   = tag;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout: in_ready=%0b, required 1 within 200 cycles", bus.in_ready);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited <= max_cyc) begin
            if (bus.out_valid) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                waited++;
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_k = '0; bus.in_din = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: %0b, required 0", bus.out_valid); end
        n_cmp++; if (bus.out_dout !== '0) begin n_err++; $display("FAIL reset_out_dout: %h, required 0", bus.out_dout); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: %0b, required 0", bus.out_err); end
        n_cmp++; if (bus.out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag: %0h, required 0", bus.out_tag); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: %0b, required 0", bus.in_ready); end
        rstn = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: %0b, required 1", bus.in_ready); end
    endtask

    task automatic test_carry();
        int acc, w;
        bit ok;
        logic [DOUT_W-1:0] d;
        send(4'd3, DIN_W'(16'hFFFF), 4'd1, acc);
        wait_valid(10, w, ok);
        n_cmp++; if (!ok || w != int'(STAGES) - 1) begin n_err++; $display("FAIL carry_latency: %0d cycles ok=%0b, required %0d", w, ok, STAGES - 1); end
        d = bus.out_dout;
        n_cmp++; if (d[SUM_W-1:0] !== 17'h1FFFD) begin n_err++; $display("FAIL carry_limb0: %h, required 1fffd", d[SUM_W-1:0]); end
        n_cmp++; if (d[2*SUM_W-1:SUM_W] !== 17'h00001) begin n_err++; $display("FAIL carry_limb1: %h, required 00001", d[2*SUM_W-1:SUM_W]); end
        n_cmp++; if (d[DOUT_W-1:2*SUM_W] !== '0) begin n_err++; $display("FAIL carry_limb23: %h, required 0", d[DOUT_W-1:2*SUM_W]); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL carry_err: %0b, required 0", bus.out_err); end
        drain();
    endtask

    task automatic test_sparse();
        int acc, w;
        bit ok;
        send(4'd12, DIN_W'(1), 4'd5, acc);
        wait_valid(10, w, ok);
        n_cmp++; if (!ok || bus.out_dout !== DOUT_W'(12)) begin n_err++; $display("FAIL sparse_dout: %h ok=%0b, required %h", bus.out_dout, ok, DOUT_W'(12)); end
        n_cmp++; if (bus.out_tag !== 4'd5) begin n_err++; $display("FAIL sparse_tag: %0h, required 5", bus.out_tag); end
        for (int k = 0; k < 16; k++) send(4'(k), DIN_W'(3), 4'(k), acc);
        drain();
    endtask

    task automatic test_illegal();
        int acc, w;
        bit ok;
        send(4'd7, DIN_W'(16'h1234), 4'd9, acc);
        wait_valid(10, w, ok);
        n_cmp++; if (!ok || w != int'(STAGES) - 1) begin n_err++; $display("FAIL illegal_latency: %0d cycles ok=%0b, required %0d", w, ok, STAGES - 1); end
        n_cmp++; if (bus.out_err !== 1'b1) begin n_err++; $display("FAIL illegal_err: %0b, required 1", bus.out_err); end
        n_cmp++; if (bus.out_dout !== '0) begin n_err++; $display("FAIL illegal_dout: %h, required 0", bus.out_dout); end
        n_cmp++; if (bus.out_tag !== 4'd9) begin n_err++; $display("FAIL illegal_tag: %0h, required 9", bus.out_tag); end
        drain();
    endtask

    task automatic test_back_to_back();
        int acc0, acc, w, run, out0;
        bit ok;
        out0 = n_out;
        acc0 = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(4'($urandom_range(0, 15)), rand_din(), 4'(i), acc);
                    if (i == 0) acc0 = acc;
                end
            end
            begin
                wait_valid(20, w, ok);
                n_cmp++; if (!ok || cyc - acc0 != int'(STAGES) - 1) begin n_err++; $display("FAIL b2b_latency: %0d cycles ok=%0b, required %0d", cyc - acc0, ok, STAGES - 1); end
                run = 0;
                while (bus.out_valid && run < 20) begin
                    run++;
                    @(posedge clk); #1;
                end
                n_cmp++; if (run != 8) begin n_err++; $display("FAIL b2b_consecutive: %0d valid cycles, required 8", run); end
            end
        join
        drain();
        n_cmp++; if (n_out - out0 != 8) begin n_err++; $display("FAIL b2b_count: %0d outputs, required 8", n_out - out0); end
    endtask

    task automatic test_backpressure();
        int acc, w, out0;
        bit ok;
        logic [DOUT_W-1:0] hold_d;
        logic [TAG_W-1:0] hold_t;
        out0 = n_out;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(4'(i + 1), rand_din(), 4'(i + 2), acc);
            end
            begin
                wait_valid(20, w, ok);
                n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_valid: out_valid=%0b, required 1", bus.out_valid); end
                hold_d = bus.out_dout;
                hold_t = bus.out_tag;
                repeat (3) begin
                    @(negedge clk);
                    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: %0b, required 0", bus.in_ready); end
                    n_cmp++; if (bus.out_dout !== hold_d || bus.out_tag !== hold_t) begin n_err++; $display("FAIL bp_hold: dout=%h tag=%0h, required dout=%h tag=%0h", bus.out_dout, bus.out_tag, hold_d, hold_t); end
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        n_cmp++; if (n_out - out0 != 4) begin n_err++; $display("FAIL bp_count: %0d outputs, required 4", n_out - out0); end
    endtask

    task automatic test_reset_midflight();
        int acc, w;
        bit ok;
        bus.out_ready = 1'b0;
        send(4'd2, rand_din(), 4'd3, acc);
        send(4'd6, rand_din(), 4'd4, acc);
        #1 rstn = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: %0b, required 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_dout !== '0) begin n_err++; $display("FAIL midrst_state: in_ready=%0b dout=%h, required 0 and 0", bus.in_ready, bus.out_dout); end
        sb.delete();
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale: out_valid=%0b, required 0", bus.out_valid); end
            @(posedge clk); #1;
        end
        send(4'd5, DIN_W'(16'hABCD), 4'hE, acc);
        wait_valid(10, w, ok);
        n_cmp++; if (!ok || bus.out_tag !== 4'hE) begin n_err++; $display("FAIL midrst_new_tag: %0h ok=%0b, required e", bus.out_tag, ok); end
        drain();
    endtask

    task automatic test_random();
        int acc;
        bit sdone;
        sdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(4'($urandom_range(0, 15)), rand_din(), 4'($urandom_range(0, 15)), acc);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                sdone = 1'b1;
            end
            begin
                while (!sdone) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_carry();
        test_sparse();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
